// File: rtl/trap_ctrl.sv
// Trap sequencer: flush, drain, write trap CSRs, redirect fetch; also arbitrates pending interrupts.
// i_trap_info layout: {cause[15:0], epc[XLEN-1:0], tval[XLEN-1:0]}. Optional: TRAP_VECTORED_EN.
module trap_ctrl #(
  parameter int unsigned XLEN = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_trap_vld,
  input  logic [16+2*XLEN-1:0]   i_trap_info,
  input  logic                   i_trap_is_irq,
  input  logic                   i_mret_vld,
  output logic                   o_trap_rdy,
  input  logic [15:0]            i_irq_pend,
  input  logic                   i_mstatus_mie,
  output logic                   o_irq_vld,
  output logic [15:0]            o_irq_cause,
  input  logic [XLEN-1:0]        i_mtvec,
  input  logic [XLEN-1:0]        i_mepc,
  output logic                   o_squash,
  input  logic                   i_drained,
  output logic                   o_csr_wen,
  output logic [XLEN-1:0]        o_mepc,
  output logic [XLEN-1:0]        o_mtval,
  output logic [XLEN-1:0]        o_mcause,
  output logic                   o_redirect_vld,
  output logic [XLEN-1:0]        o_redirect_pc,
  input  logic                   i_redirect_rdy
);

  typedef enum logic [1:0] {StIdle, StFlush, StDrain, StRedirect} state_e;

  state_e            state_q, state_d;
  logic              is_mret_q;
  logic              is_irq_q;
  logic [15:0]       cause_q;
  logic [XLEN-1:0]   epc_q;
  logic [XLEN-1:0]   tval_q;
  logic [XLEN-1:0]   target_q;
  logic [XLEN-1:0]   target;
  logic [XLEN-1:0]   base;
  logic              accept;
  logic              drain_done;

  assign accept     = (state_q == StIdle) && (i_trap_vld || i_mret_vld);
  assign drain_done = (state_q == StDrain) && i_drained;
  assign base       = {i_mtvec[XLEN-1:2], 2'b00};

  always_comb begin
    if (is_mret_q) begin
      target = {epc_q[XLEN-1:1], 1'b0};
    end else begin
`ifdef TRAP_VECTORED_EN
      if (is_irq_q && (i_mtvec[1:0] == 2'b01)) begin
        target = base + ({{(XLEN-16){1'b0}}, cause_q} << 2);
      end else begin
        target = base;
      end
`else
      target = base;
`endif
    end
  end

`ifndef TRAP_VECTORED_EN
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^i_mtvec[1:0];
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (accept) state_d = StFlush;
      StFlush:    state_d = StDrain;
      StDrain:    if (i_drained) state_d = StRedirect;
      StRedirect: if (i_redirect_rdy) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      is_mret_q <= 1'b0;
      is_irq_q  <= 1'b0;
      cause_q   <= '0;
      epc_q     <= '0;
      tval_q    <= '0;
      target_q  <= '0;
    end else begin
      state_q <= state_d;
      // A trap colliding with mret wins; the mret is simply dropped.
      if (accept && i_trap_vld) begin
        {cause_q, epc_q, tval_q} <= i_trap_info;
        is_irq_q                 <= i_trap_is_irq;
        is_mret_q                <= 1'b0;
      end else if (accept) begin
        epc_q     <= i_mepc;
        cause_q   <= '0;
        tval_q    <= '0;
        is_irq_q  <= 1'b0;
        is_mret_q <= 1'b1;
      end
      if (drain_done) target_q <= target;
    end
  end

  assign o_trap_rdy     = (state_q == StIdle);
  assign o_squash       = (state_q == StFlush);
  assign o_csr_wen      = drain_done && !is_mret_q;
  assign o_mepc         = epc_q;
  assign o_mtval        = is_irq_q ? '0 : tval_q;
  assign o_mcause       = {is_irq_q, {(XLEN-17){1'b0}}, cause_q};
  assign o_redirect_vld = (state_q == StRedirect);
  assign o_redirect_pc  = target_q;

  // Architectural priority: MEI > MSI > MTI > SEI > SSI > STI.
  always_comb begin
    o_irq_cause = '0;
    if      (i_irq_pend[11]) o_irq_cause = 16'd11;
    else if (i_irq_pend[3])  o_irq_cause = 16'd3;
    else if (i_irq_pend[7])  o_irq_cause = 16'd7;
    else if (i_irq_pend[9])  o_irq_cause = 16'd9;
    else if (i_irq_pend[1])  o_irq_cause = 16'd1;
    else if (i_irq_pend[5])  o_irq_cause = 16'd5;
  end

  assign o_irq_vld = (state_q == StIdle) && i_mstatus_mie &&
                     (|{i_irq_pend[11], i_irq_pend[9], i_irq_pend[7],
                        i_irq_pend[5], i_irq_pend[3], i_irq_pend[1]});

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: exception, irq, arbitration, mret, backpressure, reset.
module tb_trap_ctrl;
  localparam int unsigned XLEN = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_trap_vld, i_trap_is_irq, i_mret_vld, i_mstatus_mie, i_drained, i_redirect_rdy;
  logic [143:0]    i_trap_info;
  logic [15:0]     i_irq_pend;
  logic [63:0]     i_mtvec, i_mepc;
  logic            o_trap_rdy, o_irq_vld, o_squash, o_csr_wen, o_redirect_vld;
  logic [15:0]     o_irq_cause;
  logic [63:0]     o_mepc, o_mtval, o_mcause, o_redirect_pc;

  int errors = 0;
  int checks = 0;

  trap_ctrl #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .i_trap_vld(i_trap_vld), .i_trap_info(i_trap_info), .i_trap_is_irq(i_trap_is_irq),
    .i_mret_vld(i_mret_vld), .o_trap_rdy(o_trap_rdy),
    .i_irq_pend(i_irq_pend), .i_mstatus_mie(i_mstatus_mie),
    .o_irq_vld(o_irq_vld), .o_irq_cause(o_irq_cause),
    .i_mtvec(i_mtvec), .i_mepc(i_mepc),
    .o_squash(o_squash), .i_drained(i_drained),
    .o_csr_wen(o_csr_wen), .o_mepc(o_mepc), .o_mtval(o_mtval), .o_mcause(o_mcause),
    .o_redirect_vld(o_redirect_vld), .o_redirect_pc(o_redirect_pc),
    .i_redirect_rdy(i_redirect_rdy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    i_trap_vld = 0; i_trap_is_irq = 0; i_mret_vld = 0; i_mstatus_mie = 0;
    i_drained = 1; i_redirect_rdy = 1; i_trap_info = '0; i_irq_pend = '0;
    i_mtvec = '0; i_mepc = '0;
    #12;
    chk("rst_rdy", 64'(o_trap_rdy), 64'd1);
    chk("rst_squash", 64'(o_squash), 64'd0);
    chk("rst_wen", 64'(o_csr_wen), 64'd0);
    chk("rst_rvld", 64'(o_redirect_vld), 64'd0);
    chk("rst_mcause", o_mcause, 64'd0);
    chk("rst_rpc", o_redirect_pc, 64'd0);
    tick();
    rst = 1'b1;
    tick();

    // Exception, drained immediately
    i_mtvec = 64'h8000_0000;
    i_trap_info = {16'd2, 64'h8000_0100, 64'h0000_0013};
    i_trap_vld = 1;
    #1;
    chk("exc_rdy_T", 64'(o_trap_rdy), 64'd1);
    tick();
    i_trap_vld = 0;
    chk("exc_squash", 64'(o_squash), 64'd1);
    chk("exc_rdy_lo", 64'(o_trap_rdy), 64'd0);
    tick();
    chk("exc_squash_off", 64'(o_squash), 64'd0);
    chk("exc_wen", 64'(o_csr_wen), 64'd1);
    chk("exc_mcause", o_mcause, 64'd2);
    chk("exc_mepc", o_mepc, 64'h8000_0100);
    chk("exc_mtval", o_mtval, 64'h13);
    tick();
    chk("exc_rvld", 64'(o_redirect_vld), 64'd1);
    chk("exc_rpc", o_redirect_pc, 64'h8000_0000);
    chk("exc_wen_once", 64'(o_csr_wen), 64'd0);
    tick();
    chk("exc_idle", 64'(o_trap_rdy), 64'd1);
    chk("exc_rvld_off", 64'(o_redirect_vld), 64'd0);

    // Interrupt with vectored mtvec
    i_mtvec = 64'h8000_0001;
    i_trap_info = {16'd7, 64'h8000_0300, 64'h0000_0055};
    i_trap_is_irq = 1; i_trap_vld = 1;
    tick();
    i_trap_vld = 0; i_trap_is_irq = 0;
    tick();
    chk("irq_wen", 64'(o_csr_wen), 64'd1);
    chk("irq_mcause", o_mcause, 64'h8000_0000_0000_0007);
    chk("irq_mtval", o_mtval, 64'd0);
    tick();
`ifdef TRAP_VECTORED_EN
    chk("irq_rpc", o_redirect_pc, 64'h8000_001C);
`else
    chk("irq_rpc", o_redirect_pc, 64'h8000_0000);
`endif
    tick();

    // Arbitration in IDLE
    i_mstatus_mie = 1; i_irq_pend = 16'h0AAA;
    #1;
    chk("arb_vld", 64'(o_irq_vld), 64'd1);
    chk("arb_all", 64'(o_irq_cause), 64'd11);
    i_mstatus_mie = 0;
    #1;
    chk("arb_mie0", 64'(o_irq_vld), 64'd0);
    i_mstatus_mie = 1; i_irq_pend = 16'h00A0;
    #1;
    chk("arb_a0", 64'(o_irq_cause), 64'd7);
    i_irq_pend = 16'h0208;
    #1;
    chk("arb_msi_sei", 64'(o_irq_cause), 64'd3);
    i_irq_pend = 16'h0555;
    #1;
    chk("arb_ignored", 64'(o_irq_vld), 64'd0);
    i_irq_pend = 16'h0800;

    // mret
    i_mepc = 64'h8000_0205; i_mret_vld = 1;
    tick();
    i_mret_vld = 0;
    chk("mret_squash", 64'(o_squash), 64'd1);
    chk("irq_vld_busy", 64'(o_irq_vld), 64'd0);
    tick();
    chk("mret_no_wen", 64'(o_csr_wen), 64'd0);
    tick();
    chk("mret_rvld", 64'(o_redirect_vld), 64'd1);
    chk("mret_rpc", o_redirect_pc, 64'h8000_0204);
    tick();
    i_irq_pend = '0; i_mstatus_mie = 0;

    // Backpressure + trap/mret collision
    i_drained = 0; i_redirect_rdy = 0;
    i_mtvec = 64'h8000_0100; i_mepc = 64'h9000_0000;
    i_trap_info = {16'd5, 64'h8000_0400, 64'h0000_00AB};
    i_trap_vld = 1; i_mret_vld = 1;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_drain_wen", 64'(o_csr_wen), 64'd0);
      chk("bp_drain_rvld", 64'(o_redirect_vld), 64'd0);
      tick();
    end
    i_drained = 1;
    #1;
    chk("bp_wen", 64'(o_csr_wen), 64'd1);
    chk("bp_mcause", o_mcause, 64'd5);
    chk("bp_mepc", o_mepc, 64'h8000_0400);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("bp_rvld", 64'(o_redirect_vld), 64'd1);
      chk("bp_rpc", o_redirect_pc, 64'h8000_0100);
      tick();
    end
    i_redirect_rdy = 1;
    i_trap_vld = 0; i_mret_vld = 0;
    #1;
    chk("bp_rpc_last", o_redirect_pc, 64'h8000_0100);
    tick();
    chk("bp_idle", 64'(o_trap_rdy), 64'd1);
    tick();
    chk("bp_mret_dropped", 64'(o_squash), 64'd0);

    // Reset during DRAIN
    i_trap_info = {16'd4, 64'h8000_0800, 64'h0000_0077};
    i_trap_vld = 1;
    tick();
    i_trap_vld = 0; i_drained = 0;
    tick();
    rst = 1'b0;
    #1;
    chk("mrst_rdy", 64'(o_trap_rdy), 64'd1);
    chk("mrst_squash", 64'(o_squash), 64'd0);
    chk("mrst_wen", 64'(o_csr_wen), 64'd0);
    chk("mrst_rvld", 64'(o_redirect_vld), 64'd0);
    chk("mrst_mepc", o_mepc, 64'd0);
    chk("mrst_mtval", o_mtval, 64'd0);
    chk("mrst_mcause", o_mcause, 64'd0);
    chk("mrst_rpc", o_redirect_pc, 64'd0);
    tick();
    rst = 1'b1;
    i_drained = 1;
    tick();
    chk("mrst_no_resume", 64'(o_squash | o_csr_wen | o_redirect_vld), 64'd0);
    chk("mrst_idle", 64'(o_trap_rdy), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Backend trap sequencer sitting directly downstream of commit: it consumes the `trapInfo_t` record (cause, epc, tval) for the oldest excepting instruction and for `mret`. It flushes the pipeline, waits for the backend to drain, latches the machine trap CSRs and redirects fetch to the handler or return address. It also arbitrates pending machine/supervisor interrupts by architectural priority and offers the winner to commit for injection.

## Interface
- `XLEN`, 64: width of pc/tval/mtvec (`XDEF`).
- `clk`  in  1  core clock.
- `rst`  in  1  asynchronous, active-low reset.
- `i_trap_vld`  in  1  commit presents a trap; accepted when `o_trap_rdy`.
- `i_trap_info`  in  `trapInfo_t`  cause/epc/tval of the trap.
- `i_trap_is_irq`  in  1  trap is an injected interrupt, not an exception.
- `i_mret_vld`  in  1  commit presents `mret`; accepted when `o_trap_rdy`.
- `o_trap_rdy`  out  1  high only in IDLE.
- `i_irq_pend`  in  16  `mip & mie`, bit n = interrupt cause n.
- `i_mstatus_mie`  in  1  global machine interrupt enable.
- `o_irq_vld`  out  1  an enabled interrupt is pending (combinational, IDLE only).
- `o_irq_cause`  out  16  winning interrupt cause.
- `i_mtvec`, `i_mepc`  in  XLEN  current CSR values.
- `o_squash`  out  1  one-cycle pipeline flush pulse.
- `i_drained`  in  1  backend (ROB, LSU, FUs) empty.
- `o_csr_wen`  out  1  one-cycle pulse: write mepc/mcause/mtval.
- `o_mepc`, `o_mtval`  out  XLEN  values to write.
- `o_mcause`  out  XLEN  `{is_irq, zero-pad, cause[15:0]}`.
- `o_redirect_vld`  out  1  fetch redirect request.
- `o_redirect_pc`  out  XLEN  redirect target.
- `i_redirect_rdy`  in  1  frontend accepts redirect.

## Operation
- States: IDLE, FLUSH, DRAIN, REDIRECT.
- IDLE:
  - On `i_trap_vld`: latch info, is_irq and kind=TRAP; go to FLUSH.
  - Else on `i_mret_vld`: latch `i_mepc` and kind=MRET; go to FLUSH.
  - Trap and mret in the same cycle: the trap wins and the mret is dropped.
- FLUSH: assert `o_squash` for one cycle, then go to DRAIN.
- DRAIN: wait for `i_drained`.
  - On the exit cycle, kind=TRAP pulses `o_csr_wen` with mepc=epc, mtval=tval (forced to 0 when is_irq) and mcause.
  - Compute the target, then go to REDIRECT.
- REDIRECT: hold `o_redirect_vld` and `o_redirect_pc` stable until `i_redirect_rdy`, then return to IDLE.
- Target, kind=TRAP: base = `{mtvec[XLEN-1:2], 2'b00}`. Vectored-mode handling is described under Configuration.
- Target, kind=MRET: the latched mepc with bit 0 cleared.
- Interrupt arbitration:
  - `o_irq_vld = IDLE & i_mstatus_mie & |i_irq_pend[11,9,7,5,3,1]`.
  - Priority order: mExter(11) > mSoft(3) > mTimer(7) > sExter(9) > sSoft(1) > sTimer(5).
  - Other bits are ignored.
  - Commit converts the offer into `i_trap_vld` with `i_trap_is_irq=1`.
- Reset mid-operation returns to IDLE immediately and discards the latched record.

## Timing
- Reset values: state=IDLE, `o_trap_rdy`=1. `o_squash`, `o_csr_wen` and `o_redirect_vld` are 0. `o_mepc`, `o_mtval`, `o_mcause` and `o_redirect_pc` are 0.
- Acceptance at cycle T gives `o_squash` at T+1.
- Earliest `o_csr_wen` and `i_drained` sampling is T+2. Earliest `o_redirect_vld` is T+3.
- Minimum trap-to-redirect latency is 3 cycles; `i_redirect_rdy` held high returns the block to IDLE at T+4.
- `o_trap_rdy` is low from T+1 until REDIRECT completes. `i_trap_vld` and `i_mret_vld` are ignored while it is low.
- `i_drained` already high on DRAIN entry exits DRAIN after one cycle.
- `o_csr_wen` fires exactly once per trap and never for mret.

## Configuration
- `TRAP_VECTORED_EN` defined:
  - When `mtvec[1:0]==1` and the trap is an interrupt, target = base + (cause << 2), with the cause zero-extended to XLEN and modulo-2^XLEN add.
  - Exceptions always use base.
- Not defined: `mtvec[1:0]` is ignored and every trap goes to base (direct only).

## Test plan
- Exception:
  - Stimulus: `i_trap_info`={cause=2, epc=0x8000_0100, tval=0x0000_0013}, mtvec=0x8000_0000, drained immediately.
  - Required: `o_squash` at T+1; `o_csr_wen` with mcause=2, mepc=0x8000_0100, mtval=0x13; redirect 0x8000_0000 at T+3.
- Vectored irq (macro on):
  - Stimulus: cause=7, is_irq, mtvec=0x8000_0001.
  - Required: mcause=0x8000_0000_0000_0007, mtval=0, redirect 0x8000_001C. With the macro off, redirect 0x8000_0000.
- Arbitration:
  - Stimulus: `i_irq_pend`=0x0AAA with mie=1.
  - Required: `o_irq_cause`=11.
  - Stimulus: mie=0 → `o_irq_vld`=0. Pend=0x00A0 → cause=7.
- mret: `i_mepc`=0x8000_0205 → no `o_csr_wen`; redirect 0x8000_0204.
- Backpressure and collision:
  - Stimulus: hold `i_drained`=0 for 5 cycles, then `i_redirect_rdy`=0 for 3 cycles; assert trap+mret together.
  - Required: the trap is taken, the redirect is stable throughout, and the mret is dropped.
- Reset mid-flow: assert `rst`=0 during DRAIN → all outputs return to reset values and `o_trap_rdy`=1.
